// File: rtl/wordle_scorer.sv
// Scores one 5-letter guess against the secret word using Wordle duplicate-letter rules,
// keeps a NUM_ROWS-deep board history for the display and tracks win/lose/guess count.
module wordle_scorer #(
  parameter int NUM_ROWS = 6,
  parameter int LW       = 8
) (
  input  logic            Clk,
  input  logic            reset,
  input  logic            start,
  input  logic            new_game,
  input  logic [5*LW-1:0] guess,
  input  logic [5*LW-1:0] answer,
  output logic            busy,
  output logic            done,
  output logic [9:0]      colors,
  output logic            win,
  output logic            lose,
  output logic [2:0]      guess_count,
  input  logic [2:0]      rd_row,
  output logic [5*LW-1:0] rd_letters,
  output logic [9:0]      rd_colors
);

  localparam logic [2:0] ROWS_MAX = 3'(NUM_ROWS);
  localparam logic [9:0] ALL_GREEN = 10'h2AA;

  typedef enum logic [1:0] {IDLE, GREEN, YELLOW, COMMIT} state_t;

  state_t          state, next_state;
  logic [5*LW-1:0] g_reg, a_reg;
  logic [LW-1:0]   g_let [5];
  logic [LW-1:0]   a_let [5];
  logic [1:0]      col [5];
  logic [4:0]      used;
  logic [2:0]      idx;
  logic [9:0]      work_colors;
  logic            accept;
  logic            y_found;
  logic [2:0]      y_pos;

  logic [5*LW-1:0] row_letters [NUM_ROWS];
  logic [9:0]      row_colors  [NUM_ROWS];

  assign accept      = start && !win && !lose && (guess_count < ROWS_MAX);
  assign work_colors = {col[0], col[1], col[2], col[3], col[4]};

  always_comb begin
    for (int i = 0; i < 5; i++) begin
      g_let[i] = g_reg[(4-i)*LW +: LW];
      a_let[i] = a_reg[(4-i)*LW +: LW];
    end
  end

  // Lowest unused answer position holding the letter at guess position idx
  always_comb begin
    y_found = 1'b0;
    y_pos   = 3'd0;
    for (int j = 0; j < 5; j++) begin
      if (!y_found && !used[j] && (a_let[j] == g_let[idx])) begin
        y_found = 1'b1;
        y_pos   = 3'(j);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (new_game) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) next_state = GREEN;
        GREEN:   next_state = YELLOW;
        YELLOW:  if (idx == 3'd4) next_state = COMMIT;
        COMMIT:  next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state != IDLE);
  end

  // new_game clears exactly like reset, which also aborts a scoring in flight
  always_ff @(posedge Clk) begin
    if (reset || new_game) begin
      g_reg       <= '0;
      a_reg       <= '0;
      used        <= '0;
      idx         <= '0;
      done        <= 1'b0;
      colors      <= '0;
      win         <= 1'b0;
      lose        <= 1'b0;
      guess_count <= '0;
      for (int i = 0; i < 5; i++) col[i] <= 2'b00;
      for (int r = 0; r < NUM_ROWS; r++) begin
        row_letters[r] <= '0;
        row_colors[r]  <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            g_reg <= guess;
            a_reg <= answer;
            used  <= '0;
            idx   <= '0;
            for (int i = 0; i < 5; i++) col[i] <= 2'b00;
          end
        end
        GREEN: begin
          for (int i = 0; i < 5; i++) begin
            if (g_let[i] == a_let[i]) begin
              col[i]  <= 2'b10;
              used[i] <= 1'b1;
            end
          end
          idx <= '0;
        end
        YELLOW: begin
          if ((col[idx] != 2'b10) && y_found) begin
            col[idx]     <= 2'b01;
            used[y_pos]  <= 1'b1;
          end
          idx <= (idx == 3'd4) ? 3'd0 : idx + 3'd1;
        end
        COMMIT: begin
          row_letters[guess_count] <= g_reg;
          row_colors[guess_count]  <= work_colors;
          colors      <= work_colors;
          guess_count <= guess_count + 3'd1;
          done        <= 1'b1;
          win         <= (work_colors == ALL_GREEN);
          lose        <= (work_colors != ALL_GREEN) && (guess_count + 3'd1 == ROWS_MAX);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_letters = '0;
    rd_colors  = '0;
    if ((rd_row < guess_count) && (rd_row < ROWS_MAX)) begin
      rd_letters = row_letters[rd_row];
      rd_colors  = row_colors[rd_row];
    end
  end

endmodule

// File: tb/tb_wordle_scorer.sv
// Directed self-checking bench for wordle_scorer: scoring rules, timing, lockout,
// abort/clear behaviour and the board read port.
module tb_wordle_scorer;

  logic        Clk = 1'b0;
  logic        reset;
  logic        start;
  logic        new_game;
  logic [39:0] guess;
  logic [39:0] answer;
  logic        busy;
  logic        done;
  logic [9:0]  colors;
  logic        win;
  logic        lose;
  logic [2:0]  guess_count;
  logic [2:0]  rd_row;
  logic [39:0] rd_letters;
  logic [9:0]  rd_colors;

  int errors = 0;
  int checks = 0;
  int busyCnt, doneCnt, doneAt;

  wordle_scorer #(.NUM_ROWS(6), .LW(8)) dut (
    .Clk(Clk), .reset(reset), .start(start), .new_game(new_game),
    .guess(guess), .answer(answer), .busy(busy), .done(done),
    .colors(colors), .win(win), .lose(lose), .guess_count(guess_count),
    .rd_row(rd_row), .rd_letters(rd_letters), .rd_colors(rd_colors)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic ng, input logic [39:0] g, input logic [39:0] a);
    start    = s;
    new_game = ng;
    guess    = g;
    answer   = a;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Pulses start with g/a, then watches 12 edges; againAt/abortAt re-pulse start or new_game
  task automatic scoreGuess(input logic [39:0] g, input logic [39:0] a, input int againAt, input int abortAt);
    busyCnt = 0;
    doneCnt = 0;
    doneAt  = -1;
    applyStimulus(1'b1, 1'b0, g, a);
    for (int n = 0; n < 12; n++) begin
      tick();
      if (busy) busyCnt++;
      if (done) begin
        doneCnt++;
        if (doneAt < 0) doneAt = n;
      end
      applyStimulus(n == againAt, n == abortAt, 40'hFFFF_FFFF_FF, ~a);
    end
    applyStimulus(1'b0, 1'b0, g, a);
  endtask

  task automatic pulseNewGame();
    applyStimulus(1'b1 & 1'b0, 1'b1, "AAAAA", "AAAAA");
    tick();
    applyStimulus(1'b0, 1'b0, "AAAAA", "AAAAA");
  endtask

  initial begin
    reset  = 1'b1;
    rd_row = 3'd0;
    applyStimulus(1'b0, 1'b0, '0, '0);
    tick();
    tick();
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_colors", 64'(colors), 64'd0);
    checkOutput("reset_win_lose", 64'({win, lose}), 64'd0);
    checkOutput("reset_count", 64'(guess_count), 64'd0);
    reset = 1'b0;
    tick();

    scoreGuess("CRANE", "CRANE", -1, -1);
    checkOutput("crane_busy_cycles", 64'(busyCnt), 64'd7);
    checkOutput("crane_done_at", 64'(doneAt), 64'd7);
    checkOutput("crane_done_count", 64'(doneCnt), 64'd1);
    checkOutput("crane_colors", 64'(colors), 64'h2AA);
    checkOutput("crane_win", 64'(win), 64'd1);
    checkOutput("crane_count", 64'(guess_count), 64'd1);
    rd_row = 3'd0;
    #1;
    checkOutput("crane_rd_letters", 64'(rd_letters), 64'(40'("CRANE")));
    checkOutput("crane_rd_colors", 64'(rd_colors), 64'h2AA);

    scoreGuess("ZZZZZ", "CRANE", -1, -1);
    checkOutput("after_win_no_done", 64'(doneCnt), 64'd0);
    checkOutput("after_win_no_busy", 64'(busyCnt), 64'd0);

    pulseNewGame();
    checkOutput("newgame_win", 64'(win), 64'd0);
    checkOutput("newgame_count", 64'(guess_count), 64'd0);

    scoreGuess("BABES", "ABBEY", -1, -1);
    checkOutput("babes_colors", 64'(colors), 64'h168);
    checkOutput("babes_win", 64'(win), 64'd0);
    scoreGuess("OOOZZ", "ROBOT", -1, -1);
    checkOutput("oooz_colors", 64'(colors), 64'h180);
    checkOutput("oooz_count", 64'(guess_count), 64'd2);
    rd_row = 3'd1;
    #1;
    checkOutput("oooz_rd_letters", 64'(rd_letters), 64'(40'("OOOZZ")));
    checkOutput("oooz_rd_colors", 64'(rd_colors), 64'h180);
    rd_row = 3'd2;
    #1;
    checkOutput("unwritten_row", 64'({rd_letters, rd_colors}), 64'd0);

    pulseNewGame();
    for (int r = 0; r < 6; r++) begin
      scoreGuess("ZZZZZ", "CRANE", -1, -1);
      checkOutput($sformatf("lose_colors_%0d", r), 64'(colors), 64'd0);
      checkOutput($sformatf("lose_flag_%0d", r), 64'(lose), (r == 5) ? 64'd1 : 64'd0);
    end
    checkOutput("lose_count", 64'(guess_count), 64'd6);
    scoreGuess("CRANE", "CRANE", -1, -1);
    checkOutput("lockout_busy", 64'(busyCnt), 64'd0);
    checkOutput("lockout_done", 64'(doneCnt), 64'd0);
    checkOutput("lockout_count", 64'(guess_count), 64'd6);
    checkOutput("lockout_win", 64'(win), 64'd0);
    for (int r = 0; r < 8; r++) begin
      rd_row = 3'(r);
      #1;
      checkOutput($sformatf("board_letters_%0d", r), 64'(rd_letters), (r < 6) ? 64'(40'("ZZZZZ")) : 64'd0);
      checkOutput($sformatf("board_colors_%0d", r), 64'(rd_colors), 64'd0);
    end

    pulseNewGame();
    scoreGuess("REACT", "CRANE", 2, -1);
    checkOutput("again_done_count", 64'(doneCnt), 64'd1);
    checkOutput("again_done_at", 64'(doneAt), 64'd7);
    checkOutput("again_colors", 64'(colors), 64'h164);
    checkOutput("again_count", 64'(guess_count), 64'd1);

    scoreGuess("CRANE", "CRANE", -1, 4);
    checkOutput("abort_done", 64'(doneCnt), 64'd0);
    checkOutput("abort_count", 64'(guess_count), 64'd0);
    checkOutput("abort_colors", 64'(colors), 64'd0);
    rd_row = 3'd0;
    #1;
    checkOutput("abort_row0", 64'({rd_letters, rd_colors}), 64'd0);
    scoreGuess("CRANE", "CRANE", -1, -1);
    checkOutput("fresh_done_at", 64'(doneAt), 64'd7);
    checkOutput("fresh_colors", 64'(colors), 64'h2AA);
    checkOutput("fresh_count", 64'(guess_count), 64'd1);

    pulseNewGame();
    scoreGuess("BABES", "ABBEY", -1, -1);
    applyStimulus(1'b1, 1'b0, "OOOZZ", "ROBOT");
    tick();
    applyStimulus(1'b0, 1'b0, "OOOZZ", "ROBOT");
    tick();
    tick();
    tick();
    checkOutput("midyellow_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("rst_mid_busy_done", 64'({busy, done}), 64'd0);
    checkOutput("rst_mid_colors", 64'(colors), 64'd0);
    checkOutput("rst_mid_win_lose", 64'({win, lose}), 64'd0);
    checkOutput("rst_mid_count", 64'(guess_count), 64'd0);

    scoreGuess("BABES", "ABBEY", -1, -1);
    checkOutput("pre_both_count", 64'(guess_count), 64'd1);
    applyStimulus(1'b1, 1'b1, "CRANE", "CRANE");
    tick();
    applyStimulus(1'b0, 1'b0, "CRANE", "CRANE");
    checkOutput("both_busy", 64'(busy), 64'd0);
    checkOutput("both_count", 64'(guess_count), 64'd0);
    doneCnt = 0;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (done || busy) doneCnt++;
    end
    checkOutput("both_no_scoring", 64'(doneCnt), 64'd0);
    rd_row = 3'd0;
    #1;
    checkOutput("both_row0", 64'({rd_letters, rd_colors}), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wordle_scorer.md
Name: wordle_scorer

Overview:
- Scores one 5-letter guess against the secret word and marks each letter green, yellow or gray, using standard Wordle duplicate-letter rules.
- Sits downstream of the guess-entry state machine, which supplies the completed guess and the secret word, and upstream of the VGA display logic.
- Keeps a 6-row board history (letters and colours) that the display reads through a combinational read port.
- Also produces the win, lose and guess-count status.

Parameters:
- NUM_ROWS, 6, number of guesses stored on the board (also the guess limit).
- LW, 8, bits per letter (ASCII); word width is 5*LW.

Ports:
- Clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse: score guess against answer.
- new_game  input  1  one-cycle pulse: clear board and status.
- guess  input  40  guessed word; letter 0 (leftmost) in [39:32], letter 4 in [7:0].
- answer  input  40  secret word, same packing as guess.
- busy  output  1  high while scoring is in progress.
- done  output  1  one-cycle pulse when the result is committed.
- colors  output  10  last result; letter i in bits [9-2i:8-2i]; 00 gray, 01 yellow, 10 green (11 never produced).
- win  output  1  sticky; last committed guess was all green.
- lose  output  1  sticky; NUM_ROWS guesses committed with no win.
- guess_count  output  3  number of committed rows, 0..NUM_ROWS.
- rd_row  input  3  display read row index.
- rd_letters  output  40  stored guess for rd_row (combinational).
- rd_colors  output  10  stored colours for rd_row (combinational).

Behaviour:
- Reset (synchronous, Clk edge with reset=1):
  - state=IDLE.
  - busy=0, done=0, colors=0, win=0, lose=0, guess_count=0.
  - All board rows cleared to 0.
  - reset overrides every other input.
- States: IDLE, GREEN, YELLOW, COMMIT.
- IDLE:
  - start is accepted only if win=0, lose=0 and guess_count<NUM_ROWS; otherwise it is ignored (no busy, no done).
  - On accept: latch guess and answer into internal registers, clear working colours and the 5-bit used mask, go to GREEN.
  - Later changes on guess or answer do not affect the scoring in progress.
- GREEN (1 cycle):
  - For each i, if g[i]==a[i] (all LW bits equal), set colour[i]=10 and used[i]=1.
  - Next state YELLOW with idx=0.
- YELLOW (5 cycles, idx 0..4, one guess position per cycle):
  - If colour[idx]!=10, find the lowest j with used[j]=0 and a[j]==g[idx].
  - If such a j exists: colour[idx]=01 and used[j]=1. Otherwise colour[idx] stays 00.
  - idx increments each cycle; after idx=4, go to COMMIT.
- COMMIT (1 cycle):
  - Write row[guess_count] = {latched guess, colours}.
  - colors <= colours, guess_count <= guess_count+1, done <= 1 for exactly one cycle.
  - win <= (colours==10'h2AA).
  - lose <= (colours!=10'h2AA && guess_count+1==NUM_ROWS).
  - Next state IDLE.
- Timing:
  - busy=1 exactly in GREEN, YELLOW and COMMIT.
  - Latency is fixed: start sampled at edge k, done high in the cycle after edge k+7, busy high for 7 cycles.
- start while busy: ignored; the in-flight scoring is unaffected.
- new_game:
  - Same effect as reset except that it is functional (a normal input), and it takes priority over start in every state.
  - Aborts any in-flight scoring: no done, no row written.
  - new_game and start in the same cycle: new_game wins and start is dropped.
- Read port:
  - rd_letters/rd_colors = row[rd_row].
  - Rows at or above guess_count read as 0, as does any rd_row>=NUM_ROWS.
  - No read latency.
- No letter validation: any byte values are compared bitwise.

Test Plan:
- Exact match: answer="CRANE", guess="CRANE", start pulse -> busy high 7 cycles; done pulse 7 cycles after start; colors=10'h2AA; win=1; guess_count=1; rd_row=0 returns "CRANE"/10'h2AA.
- Duplicates, answer has extra: answer="ABBEY", guess="BABES" -> colors=10'h168 (Y,Y,G,G,gray); win=0.
- Duplicates, guess has extra: answer="ROBOT", guess="OOOZZ" -> colors=10'h180 (Y,G,gray,gray,gray); the third O is gray because both O's in the answer are already used.
- Lose and lockout:
  - Six wrong guesses ("ZZZZZ" vs "CRANE") -> colors=0 each time; lose=1 after the 6th done; guess_count=6.
  - A 7th start -> no busy, no done; state unchanged.
  - Board rows 0..5 each read "ZZZZZ"/0.
- Start while busy: second start pulse at cycle k+3 -> still exactly one done at k+7 and guess_count increments by 1.
- Abort and clear:
  - new_game at cycle k+4 of a scoring -> no done; guess_count=0; all rows read 0; a fresh start then scores normally.
  - reset asserted mid-YELLOW -> all outputs 0 on the next cycle.
  - new_game and start in the same cycle -> board cleared and no scoring begins.
